// File: rtl/aes_pkg.sv
// Shared AES column-mix definitions: FSM encoding, GF(2^8) coefficients, constant multiply.
// Forward coefficients are only referenced when FWD_MODE_EN is defined.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [7:0] C_0E     = 8'h0E;
  localparam logic [7:0] C_0B     = 8'h0B;
  localparam logic [7:0] C_0D     = 8'h0D;
  localparam logic [7:0] C_09     = 8'h09;
  localparam logic [7:0] C_02     = 8'h02;
  localparam logic [7:0] C_03     = 8'h03;
  localparam logic [7:0] C_01     = 8'h01;
  localparam logic [7:0] RED_POLY = 8'h1B;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? RED_POLY : 8'h00);
  endfunction

  // Coefficient is always a constant at the call site, so the case folds away.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      C_09:    return x8 ^ a;
      C_0B:    return x8 ^ x2 ^ a;
      C_0D:    return x8 ^ x4 ^ a;
      C_0E:    return x8 ^ x4 ^ x2;
      C_02:    return x2;
      C_03:    return x2 ^ a;
      C_01:    return a;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational (Inv)MixColumns of one 32-bit column; row 0 in bits [31:24].
// With FWD_MODE_EN defined, mode_i=1 selects the forward matrix.
module inv_mix_single_column
  import aes_pkg::*;
(
`ifdef FWD_MODE_EN
  input  logic        mode_i,
`endif
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  // Row 0 of each circulant matrix; row r uses entry (j - r) mod 4 for input row j.
  localparam logic [3:0][7:0] INV_ROW = {C_09, C_0D, C_0B, C_0E};
`ifdef FWD_MODE_EN
  localparam logic [3:0][7:0] FWD_ROW = {C_01, C_01, C_03, C_02};
`endif

  logic [3:0][7:0] a, inv;
`ifdef FWD_MODE_EN
  logic [3:0][7:0] fwd;
`endif

  always_comb begin
    a   = '0;
    inv = '0;
    for (int r = 0; r < 4; r++) a[r] = col_i[31-8*r -: 8];
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        inv[r] = inv[r] ^ gf_mul_const(a[j], INV_ROW[2'(j - r)]);
  end

`ifdef FWD_MODE_EN
  always_comb begin
    fwd = '0;
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++)
        fwd[r] = fwd[r] ^ gf_mul_const(a[j], FWD_ROW[2'(j - r)]);
  end
`endif

  always_comb begin
    col_o = '0;
    for (int r = 0; r < 4; r++) begin
`ifdef FWD_MODE_EN
      col_o[31-8*r -: 8] = mode_i ? fwd[r] : inv[r];
`else
      col_o[31-8*r -: 8] = inv[r];
`endif
    end
  end

endmodule

// File: rtl/inv_mix_column_seq.sv
// Iterative AES InvMixColumns: captures a state, mixes COLS_PER_CYCLE columns per clock.
// FWD_MODE_EN adds a Mode port selecting the forward MixColumns matrix.
module inv_mix_column_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         In_Valid,
  output logic         In_Ready,
  input  logic [127:0] Input,
`ifdef FWD_MODE_EN
  input  logic         Mode,
`endif
  output logic         Out_Valid,
  input  logic         Out_Ready,
  output logic [127:0] Output,
  output logic         Busy
);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("inv_mix_column_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  // Column c lives at index 3-c so that column 0 sits in bits [127:96].
  logic [3:0][31:0] cap_q, cap_d;
  logic [3:0][31:0] out_q, out_d;
`ifdef FWD_MODE_EN
  logic            mode_q, mode_d;
`endif

  logic [COLS_PER_CYCLE-1:0][1:0]  col_idx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_res;

  always_comb begin
    col_idx = '0;
    col_in  = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_idx[g] = cnt_q + 2'(g);
      col_in[g]  = cap_q[2'd3 - col_idx[g]];
    end
  end

  generate
    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      inv_mix_single_column u_col (
`ifdef FWD_MODE_EN
        .mode_i(mode_q),
`endif
        .col_i (col_in[g]),
        .col_o (col_res[g])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    out_d   = out_q;
`ifdef FWD_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (In_Valid) begin
          cap_d   = Input;
          cnt_d   = '0;
`ifdef FWD_MODE_EN
          mode_d  = Mode;
`endif
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        for (int g = 0; g < COLS_PER_CYCLE; g++) out_d[2'd3 - col_idx[g]] = col_res[g];
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (Out_Ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      out_q   <= '0;
`ifdef FWD_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
`ifdef FWD_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign In_Ready  = (state_q == ST_IDLE);
  assign Out_Valid = (state_q == ST_DONE);
  assign Busy      = (state_q != ST_IDLE);
  assign Output    = out_q;

endmodule

// File: tb/tb_inv_mix_column_seq.sv
// Bench for inv_mix_column_seq: three instances (1, 2, 4 columns/cycle) against a matrix-level model.
module tb_inv_mix_column_seq;

  localparam logic [127:0] V1    = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] O1    = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2    = 128'hd5d5d7d6_4d7ebdf8_c6c6c6c6_01010101;
  localparam logic [127:0] O2    = 128'hd4d4d4d5_2d26314c_c6c6c6c6_01010101;
  localparam logic [127:0] ALL_F = {128{1'b1}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [127:0] inp;
`ifdef FWD_MODE_EN
  logic         mode;
`endif
  logic [2:0]   in_ready, out_valid, busy;
  logic [127:0] outp [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_column_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .In_Valid (in_valid),
      .In_Ready (in_ready[g]),
      .Input    (inp),
`ifdef FWD_MODE_EN
      .Mode     (mode),
`endif
      .Out_Valid(out_valid[g]),
      .Out_Ready(out_ready),
      .Output   (outp[g]),
      .Busy     (busy[g])
    );
  end

  // GF(2^8) multiply by shift-and-add over the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input int r, input int j, input logic fwd);
    int k = (j - r + 4) % 4;
    if (fwd) begin
      case (k)
        0:       return 8'h02;
        1:       return 8'h03;
        default: return 8'h01;
      endcase
    end
    case (k)
      0:       return 8'h0e;
      1:       return 8'h0b;
      2:       return 8'h0d;
      default: return 8'h09;
    endcase
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic fwd);
    logic [127:0] res = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef(r, j, fwd), s[127-8*(4*c+j) -: 8]);
        res[127-8*(4*c+r) -: 8] = acc;
      end
    return res;
  endfunction

  function automatic logic cur_mode();
`ifdef FWD_MODE_EN
    return mode;
`else
    return 1'b0;
`endif
  endfunction

  // Transaction-level expectation: 0=idle, 1=computing (m_cnt edges left), 2=result held.
  int           m_st  [3];
  int           m_cnt [3];
  logic [127:0] m_out [3];
  logic [127:0] m_exp [3];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_st[i]  <= 0;
        m_cnt[i] <= 0;
        m_out[i] <= '0;
        m_exp[i] <= '0;
      end else begin
        case (m_st[i])
          0: if (in_valid) begin
               m_exp[i] <= ref_mix(inp, cur_mode());
               m_cnt[i] <= 4 >> i;
               m_st[i]  <= 1;
             end
          1: if (m_cnt[i] == 1) begin
               m_st[i]  <= 2;
               m_out[i] <= m_exp[i];
             end else m_cnt[i] <= m_cnt[i] - 1;
          default: if (out_ready) m_st[i] <= 0;
        endcase
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("in_ready[%0d]", i),  in_ready[i],  m_st[i] == 0);
      chk($sformatf("out_valid[%0d]", i), out_valid[i], m_st[i] == 2);
      chk($sformatf("busy[%0d]", i),      busy[i],      m_st[i] != 0);
      if (m_st[i] != 1) chk($sformatf("output[%0d]", i), outp[i], m_out[i]);
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic lat_test(input logic [127:0] vin, input logic [127:0] vexp);
    inp = vin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; inp = ALL_F;
    for (int k = 1; k <= 6; k++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("lat_vld[%0d]k%0d", i, k), out_valid[i], k == (4 >> i));
        if (k == (4 >> i)) chk($sformatf("lat_out[%0d]", i), outp[i], vexp);
      end
    end
  endtask

  task automatic txn(input logic [127:0] vin, output logic [127:0] res);
    logic got = 1'b0;
    res = '0;
    inp = vin; in_valid = 1'b1;
    step();
    in_valid = 1'b0; inp = ALL_F;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (out_valid[0]) begin got = 1'b1; res = outp[0]; end
    end
    chk("txn_timeout", got, 1'b1);
    step();
  endtask

  initial begin
    logic [127:0] x, r1, r2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inp = '0;
`ifdef FWD_MODE_EN
    mode = 1'b0;
`endif
    step(); step();
    for (int i = 0; i < 3; i++) chk($sformatf("rst_out[%0d]", i), outp[i], 128'h0);
    rst_n = 1'b1;
    step();

    chk("pin_inv_v1", ref_mix(V1, 1'b0), O1);
    chk("pin_inv_v2", ref_mix(V2, 1'b0), O2);
    chk("pin_fwd_o1", ref_mix(O1, 1'b1), V1);
    x = {$urandom, $urandom, $urandom, $urandom};
    chk("pin_roundtrip", ref_mix(ref_mix(x, 1'b1), 1'b0), x);

    lat_test(V1, O1);
    lat_test(V2, O2);

    // Backpressure with a second request pending.
    out_ready = 1'b0; inp = V2; in_valid = 1'b1;
    step();
    inp = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k >= 4) begin
        chk("bp_vld", out_valid[0], 1'b1);
        chk("bp_out", outp[0], O2);
        chk("bp_rdy", in_ready[0], 1'b0);
      end
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_rdy", in_ready[0], 1'b1);
    chk("bp_rel_vld", out_valid[0], 1'b0);
    step();
    chk("bp_accept", busy[0], 1'b1);
    in_valid = 1'b0;
    repeat (6) step();

    // Reset two cycles into a computation.
    inp = V1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("mrst_vld[%0d]", i), out_valid[i], 1'b0);
      chk($sformatf("mrst_out[%0d]", i), outp[i], 128'h0);
      chk($sformatf("mrst_rdy[%0d]", i), in_ready[i], 1'b1);
    end
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mrst_no_result", out_valid[0], 1'b0);
    end

`ifdef FWD_MODE_EN
    mode = 1'b1;
    txn(O1, r1);
    chk("fwd_o1", r1, V1);
    mode = 1'b0;
    txn(r1, r2);
    chk("fwd_back_inv", r2, O1);
`else
    txn(V1, r1);
    txn(r1, r2);
    chk("inv_v1", r1, O1);
    chk("inv_twice", r2, ref_mix(O1, 1'b0));
`endif

    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      inp       = {$urandom, $urandom, $urandom, $urandom};
`ifdef FWD_MODE_EN
      mode      = 1'($urandom_range(0, 1));
`endif
      rst_n     = (c != 300);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
